// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed 32x32 multiply / 32/32 divide unit with HI/LO result registers
//
// Ports:
//   clock    - single clock, all state changes on the rising edge
//   reset    - synchronous active-high reset, aborts any operation in flight
//   start    - one-cycle request, accepted only while busy is low
//   op       - 0 = signed multiply, 1 = signed divide (sampled with start)
//   a_in     - multiplicand / dividend
//   b_in     - multiplier / divisor
//   busy     - high from the cycle after an accepted start through the done cycle
//   done     - one-cycle completion pulse
//   div_zero - high in the done cycle of a divide by zero
//   hi_out   - HI register (product high word / remainder)
//   lo_out   - LO register (product low word / quotient)

module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state;
    logic        op_r;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [4:0]  count;
    // mult: {P_hi, remaining multiplier bits}; div: {remainder, quotient}
    logic [63:0] acc;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] add_sum;
    logic [32:0] trial;
    logic [63:0] step_acc;
    logic        res_neg;
    logic [63:0] mult_res;
    logic [31:0] div_lo;
    logic [31:0] div_hi;

    always_comb begin
        abs_a = a_in[31] ? (32'd0 - a_in) : a_in;
        abs_b = b_in[31] ? (32'd0 - b_in) : b_in;

        // 33-bit intermediates: the shifted partial product and the shifted
        // remainder can both exceed 32 bits for a single cycle.
        add_sum = {1'b0, acc[63:32]} + {1'b0, mag_a};
        trial   = acc[63:31] - {1'b0, mag_b};

        if (!op_r) begin
            step_acc = acc[0] ? {add_sum, acc[31:1]} : {1'b0, acc[63:1]};
        end else if (trial[32]) begin
            step_acc = {acc[62:0], 1'b0};
        end else begin
            step_acc = {trial[31:0], acc[30:0], 1'b1};
        end

        res_neg  = sign_a ^ sign_b;
        mult_res = res_neg ? (64'd0 - step_acc) : step_acc;
        // Remainder takes the dividend's sign so the quotient truncates toward zero.
        div_lo   = res_neg ? (32'd0 - step_acc[31:0]) : step_acc[31:0];
        div_hi   = sign_a ? (32'd0 - step_acc[63:32]) : step_acc[63:32];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            op_r     <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            mag_a    <= 32'd0;
            mag_b    <= 32'd0;
            count    <= 5'd0;
            acc      <= 64'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= 32'd0;
            lo_out   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r   <= op;
                        sign_a <= a_in[31];
                        sign_b <= b_in[31];
                        mag_a  <= abs_a;
                        mag_b  <= abs_b;
                        count  <= 5'd0;
                        acc    <= op ? {32'd0, abs_a} : {32'd0, abs_b};
                        busy   <= 1'b1;
                        if (op && (b_in == 32'd0)) begin
                            // HI/LO deliberately untouched on divide by zero.
                            state    <= FINISH;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc   <= step_acc;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        if (!op_r) begin
                            hi_out <= mult_res[63:32];
                            lo_out <= mult_res[31:0];
                        end else begin
                            hi_out <= div_hi;
                            lo_out <= div_lo;
                        end
                    end
                end
                FINISH: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against a plain-arithmetic model

module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mult_div_unit dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: 64-bit signed arithmetic, SV / and % truncate toward zero.
    task automatic model(input logic o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!o) begin
            v = sa * sb;
            exp_hi = v[63:32];
            exp_lo = v[31:0];
        end else if (b != 32'd0) begin
            v = sa / sb;
            exp_lo = v[31:0];
            v = sa % sb;
            exp_hi = v[31:0];
        end
    endtask

    // Starts an op in the current cycle T, follows it to idle and checks the
    // handshake timing, the result and div_zero. interfere>0 pulses a second
    // start with random operands during cycle T+interfere.
    task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         input int interfere, input string name);
        int   lat;
        int   done_at;
        int   done_cnt;
        logic busy_bad;
        logic got_dz;
        logic [31:0] got_hi;
        logic [31:0] got_lo;
        logic exp_dz;
        exp_dz   = o && (b == 32'd0);
        lat      = exp_dz ? 1 : 33;
        model(o, a, b);
        done_at  = 0;
        done_cnt = 0;
        busy_bad = 1'b0;
        got_dz   = 1'b0;
        got_hi   = 32'd0;
        got_lo   = 32'd0;
        start = 1'b1; op = o; a_in = a; b_in = b;
        tick();
        start = 1'b0; a_in = $urandom; b_in = $urandom;
        for (int k = 1; k <= lat + 1; k++) begin
            if (busy !== (k <= lat)) busy_bad = 1'b1;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            if (k == lat) begin
                got_hi = hi_out;
                got_lo = lo_out;
                got_dz = div_zero;
            end
            if (k == interfere) begin
                start = 1'b1; op = 1'($urandom); a_in = $urandom; b_in = $urandom_range(3, 0);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (done_at !== lat || done_cnt !== 1) begin
            errors++;
            $display("FAIL %s done_timing: got first=%0d count=%0d, want first=%0d count=1", name, done_at, done_cnt, lat);
        end
        checks++;
        if (busy_bad !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_window: busy not high exactly for cycles 1..%0d", name, lat);
        end
        checks++;
        if (got_hi !== exp_hi || got_lo !== exp_lo) begin
            errors++;
            $display("FAIL %s result: got hi=%h lo=%h, want hi=%h lo=%h", name, got_hi, got_lo, exp_hi, exp_lo);
        end
        checks++;
        if (got_dz !== exp_dz) begin
            errors++;
            $display("FAIL %s div_zero: got %b, want %b", name, got_dz, exp_dz);
        end
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            errors++;
            $display("FAIL %s: got busy=%b done=%b dz=%b hi=%h lo=%h, want all zero",
                     name, busy, done, div_zero, hi_out, lo_out);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = 1'b0; a_in = 32'd5; b_in = 32'd6;
        tick();
        tick();
        reset = 1'b0; start = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        check_idle_zero("reset_values");
        tick();
        tick();
        check_idle_zero("reset_no_op_started");
    endtask

    task automatic test_mult();
        do_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 0, "mult_7x-3");
        checks++;
        if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mult_7x-3_const: got hi=%h lo=%h, want hi=ffffffff lo=ffffffeb", hi_out, lo_out);
        end
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0, "mult_min_x_min");
        checks++;
        if (hi_out !== 32'h4000_0000 || lo_out !== 32'h0000_0000) begin
            errors++;
            $display("FAIL mult_min_x_min_const: got hi=%h lo=%h, want hi=40000000 lo=00000000", hi_out, lo_out);
        end
        do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 0, "mult_-1x1");
        do_op(1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 0, "mult_zero");
    endtask

    task automatic test_div();
        do_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, "div_-7/2");
        checks++;
        if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_-7/2_const: got hi=%h lo=%h, want hi=ffffffff lo=fffffffd", hi_out, lo_out);
        end
        do_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 0, "div_7/-2");
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min/-1");
        checks++;
        if (hi_out !== 32'h0000_0000 || lo_out !== 32'h8000_0000) begin
            errors++;
            $display("FAIL div_min/-1_const: got hi=%h lo=%h, want hi=00000000 lo=80000000", hi_out, lo_out);
        end
        do_op(1'b1, 32'h0000_0003, 32'h0000_0007, 0, "div_small/large");
    endtask

    task automatic test_div_zero();
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        do_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF1, 0, "div_zero_setup_mult");
        prev_hi = exp_hi;
        prev_lo = exp_lo;
        do_op(1'b1, 32'h0000_0005, 32'h0000_0000, 0, "div_5/0");
        checks++;
        if (hi_out !== prev_hi || lo_out !== prev_lo) begin
            errors++;
            $display("FAIL div_zero_hold: got hi=%h lo=%h, want hi=%h lo=%h", hi_out, lo_out, prev_hi, prev_lo);
        end
    endtask

    task automatic test_back_to_back();
        do_op(1'b0, 32'h0001_0003, 32'hFFFE_0001, 5, "ignored_start_run");
        do_op(1'b1, 32'h7FFF_FFFF, 32'h0000_0010, 33, "ignored_start_finish");
        do_op(1'b1, 32'h0000_0009, 32'h0000_0000, 1, "ignored_start_dz");
    endtask

    task automatic test_abort();
        int done_seen;
        done_seen = 0;
        start = 1'b1; op = 1'b0; a_in = 32'h0000_1234; b_in = 32'h0000_5678;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (done === 1'b1) done_seen++;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        check_idle_zero("abort_cleared");
        for (int k = 0; k < 40; k++) begin
            if (k == 0) begin
                if (done === 1'b1) done_seen++;
            end else begin
                if (done === 1'b1 || busy === 1'b1) done_seen++;
                tick();
            end
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done/busy cycles, want 0", done_seen);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b1; op = 1'b0; a_in = 32'd1; b_in = 32'd1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        do_op(1'b0, 32'hFFFF_FF00, 32'h0000_0100, 0, "after_abort_start");
    endtask

    task automatic test_random();
        logic        o;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 24; i++) begin
            o = 1'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(5, 0))
                0: a = 32'h8000_0000;
                1: b = 32'h0000_0000;
                2: b = $urandom_range(16, 0) - 8;
                3: a = $urandom_range(100, 0);
                default: ;
            endcase
            do_op(o, a, b, 0, "random");
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; a_in = 32'd0; b_in = 32'd0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
